// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the parametrised datapath buffers.
// Every block derives its pointer and occupancy widths from these functions.
package fifo_pkg;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy has to represent DEPTH itself, hence the +1.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEFAULT_DEPTH = 16;

  typedef logic [count_width(DEFAULT_DEPTH)-1:0] fifo_count_t;

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer valid-ready handshake bundle for sync_fifo_param.
interface sync_fifo_param_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] idata;
  logic             ivalid;
  logic             iready;
  logic [WIDTH-1:0] odata;
  logic             ovalid;
  logic             oready;

  modport master (
    output idata, ivalid, oready,
    input  iready, odata, ovalid
  );

  modport slave (
    input  idata, ivalid, oready,
    output iready, odata, ovalid
  );

endinterface

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = addr_width(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; the pointers alone decide what is valid,
  // so clearing the array would only cost a reset net to every bit.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// First-word-fall-through synchronous FIFO with valid/ready on both sides and flush.
// Optional high-watermark register enabled by defining SYNC_FIFO_PEAK_EN.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = DEPTH - 2,
  localparam int CW       = count_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  sync_fifo_param_if.slave bus,
  output logic [CW-1:0]    count,
  output logic             afull,
  output logic [CW-1:0]    peak
);

  localparam int AW = addr_width(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] count_t;

  ptr_t   wr_ptr, rd_ptr;
  logic   full, empty, push, pop;

  assign full  = (count == count_t'(DEPTH));
  assign empty = (count == '0);

  // iready also drops while reset is held so nothing is offered a handshake.
  assign bus.iready = reset && !full;
  assign bus.ovalid = !empty;
  assign afull      = (count >= count_t'(AFULL_LVL));

  assign push = bus.ivalid && bus.iready;
  assign pop  = bus.ovalid && bus.oready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef SYNC_FIFO_PEAK_EN
  // count never exceeds DEPTH, so the watermark saturates there on its own.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      peak <= '0;
    end else if (flush) begin
      peak <= '0;
    end else if (count > peak) begin
      peak <= count;
    end
  end
`else
  assign peak = '0;
`endif

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clock (clock),
    .we    (push && !flush),
    .waddr (wr_ptr),
    .wdata (bus.idata),
    .raddr (rd_ptr),
    .rdata (bus.odata)
  );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (WIDTH=8, DEPTH=16, AFULL_LVL=14).
// Peak expectations follow SYNC_FIFO_PEAK_EN when the bench is built with it.
module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] count;
  logic          afull;
  logic [CW-1:0] peak;

  int total = 0;
  int bad   = 0;

  sync_fifo_param_if #(.WIDTH(WIDTH)) bus ();

  sync_fifo_param #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AFULL_LVL (14)
  ) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave),
    .count (count),
    .afull (afull),
    .peak  (peak)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.idata  = '0;
    bus.ivalid = 1'b0;
    bus.oready = 1'b0;

    // Reset state while reset is held.
    #3;
    check("rst_iready", bus.iready, 0);
    check("rst_ovalid", bus.ovalid, 0);
    check("rst_count",  count, 0);
    check("rst_afull",  afull, 0);
    check("rst_peak",   peak, 0);
    tick();
    reset = 1'b1;
    #1;
    check("rel_iready", bus.iready, 1);

    // Reset mid-stream: five words, then an asynchronous reset pulse.
    bus.ivalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.idata = 8'(8'h10 + i);
      tick();
    end
    check("mid_count5", count, 5);
    check("mid_head",   bus.odata, 8'h10);
    #2;
    reset = 1'b0;
    #1;
    check("async_count",  count, 0);
    check("async_ovalid", bus.ovalid, 0);
    check("async_iready", bus.iready, 0);
    bus.ivalid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("async_rel_iready", bus.iready, 1);
    check("async_rel_count",  count, 0);

    // Fill 0x00..0x0F; afull rises on the 14th push, iready falls on the 16th.
    bus.ivalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.idata = 8'(i);
      tick();
      if (i == 12) check("afull_after13", afull, 0);
      if (i == 13) check("afull_after14", afull, 1);
    end
    check("full_iready", bus.iready, 0);
    check("full_count",  count, 16);
`ifdef SYNC_FIFO_PEAK_EN
    check("full_peak_lag", peak, 15);
`else
    check("full_peak_off", peak, 0);
`endif
    bus.idata = 8'hAA;
    tick();
    check("drop17_count", count, 16);
    check("drop17_head",  bus.odata, 8'h00);
`ifdef SYNC_FIFO_PEAK_EN
    check("full_peak", peak, 16);
`endif

    // Full with push+pop: pop taken, push refused.
    bus.idata  = 8'hBB;
    bus.oready = 1'b1;
    tick();
    check("fullpp_count",  count, 15);
    check("fullpp_head",   bus.odata, 8'h01);
    check("fullpp_iready", bus.iready, 1);

    // Drain the rest in order; 0xAA and 0xBB must never appear.
    bus.ivalid = 1'b0;
    for (int i = 1; i < 16; i++) begin
      check($sformatf("drain_%0d", i), bus.odata, 32'(i));
      tick();
    end
    bus.oready = 1'b0;
    check("drain_ovalid", bus.ovalid, 0);
    check("drain_count",  count, 0);

    // Empty with push+pop: push taken, pop ignored.
    bus.ivalid = 1'b1;
    bus.oready = 1'b1;
    bus.idata  = 8'h55;
    tick();
    check("emptypp_count",  count, 1);
    check("emptypp_ovalid", bus.ovalid, 1);
    check("emptypp_head",   bus.odata, 8'h55);
    bus.ivalid = 1'b0;
    tick();
    check("emptypp_popped", count, 0);

    // Advance both pointers to 12 so the next burst wraps past 15.
    bus.oready = 1'b0;
    bus.ivalid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      bus.idata = 8'(8'h40 + i);
      tick();
    end
    bus.ivalid = 1'b0;
    bus.oready = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    bus.oready = 1'b0;
    check("adv_count", count, 0);

    bus.ivalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.idata = 8'(8'h20 + i);
      tick();
    end
    check("wrap_count", count, 8);
    check("wrap_head",  bus.odata, 8'h20);

    // Simultaneous push+pop mid-occupancy holds count.
    bus.idata  = 8'h28;
    bus.oready = 1'b1;
    tick();
    check("pp_count", count, 8);
    check("pp_head",  bus.odata, 8'h21);
    bus.ivalid = 1'b0;
    for (int i = 1; i < 9; i++) begin
      check($sformatf("wrap_rd_%0d", i), bus.odata, 32'(8'h20 + i));
      tick();
    end
    bus.oready = 1'b0;
    check("wrap_empty", bus.ovalid, 0);

    // Plain flush clears contents and the watermark.
    bus.ivalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.idata = 8'(8'h60 + i);
      tick();
    end
    bus.ivalid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush1_count",  count, 0);
    check("flush1_ovalid", bus.ovalid, 0);
    check("flush1_peak",   peak, 0);

    // Flush at count=9 overriding a concurrent push and pop.
    bus.ivalid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.idata = 8'(8'h70 + i);
      tick();
    end
    bus.ivalid = 1'b0;
    tick();
    check("pre_flush_count", count, 9);
    check("pre_flush_head",  bus.odata, 8'h70);
`ifdef SYNC_FIFO_PEAK_EN
    check("pre_flush_peak", peak, 9);
`else
    check("pre_flush_peak", peak, 0);
`endif
    bus.ivalid = 1'b1;
    bus.oready = 1'b1;
    bus.idata  = 8'h99;
    flush      = 1'b1;
    tick();
    flush      = 1'b0;
    bus.ivalid = 1'b0;
    bus.oready = 1'b0;
    check("flush2_count",  count, 0);
    check("flush2_ovalid", bus.ovalid, 0);
    check("flush2_peak",   peak, 0);
    check("flush2_iready", bus.iready, 1);

    // After flush the next word is at the head again.
    bus.ivalid = 1'b1;
    bus.idata  = 8'h77;
    tick();
    bus.ivalid = 1'b0;
    check("post_flush_count", count, 1);
    check("post_flush_head",  bus.odata, 8'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO with valid/ready handshakes on both sides, full/empty/almost-full status and a synchronous flush. It is the next-generation buffer between producer and consumer stages in the MPI datapath. Generalises width and depth, adds explicit backpressure (`iready`), output validity (`ovalid`) and correct full/empty protection.

## Interface
- `WIDTH`, 8, data word width in bits (≥1).
- `DEPTH`, 16, number of entries; power of two, ≥2.
- `AFULL_LVL`, DEPTH-2, almost-full threshold; range 1..DEPTH.
- `clock`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of contents.
- `idata`  in  WIDTH  write data.
- `ivalid`  in  1  producer offers `idata`.
- `iready`  out  1  FIFO can accept a word.
- `odata`  out  WIDTH  head-of-queue data.
- `ovalid`  out  1  `odata` holds a valid word.
- `oready`  in  1  consumer takes `odata`.
- `count`  out  CW  occupancy, CW = $clog2(DEPTH+1).
- `afull`  out  1  count ≥ AFULL_LVL.
- `peak`  out  CW  high-watermark (see Configuration).

## Operation
- Push = `ivalid && iready`; pop = `ovalid && oready`. Only handshaken transfers change state.
- `iready` = !full && reset deasserted; `ovalid` = count != 0.
- Push writes `mem[wr_ptr]`, wr_ptr+1; pop advances rd_ptr+1. Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 → 0 naturally.
- `odata` = `mem[rd_ptr]`, read combinationally (first-word-fall-through). It is don't-care when `ovalid`=0.
- count: push only +1; pop only −1; both or neither unchanged. Never exceeds DEPTH and never underflows, by construction.
- Full (count==DEPTH): `iready`=0, `ivalid` is ignored; a pop in the same cycle is still honoured. No push occurs that cycle.
- Empty: `ovalid`=0, `oready` is ignored; a push in the same cycle is honoured.
- Simultaneous push+pop at non-boundary occupancy: both proceed, count held.
- `flush`=1: next edge sets wr_ptr=rd_ptr=0 and count=0. Flush overrides any push or pop in the same cycle. Memory contents are not cleared.
- Reset (async, any time, including mid-transfer): pointers=0, count=0, `peak`=0. Memory array is not reset. A transfer in progress is lost.

## Timing
- Reset values: `iready`=0 while `reset`=0, 1 after release; `ovalid`=0; `count`=0; `afull`=0 (AFULL_LVL≥1); `peak`=0; `odata` undefined.
- Write-to-read latency is 1 cycle: a word pushed at edge N is visible with `ovalid`=1 after edge N.
- `count`, `afull`, `iready` and `ovalid` all update on the same edge as the transfer that changes them. No status lookahead.
- Throughput is one push and one pop per cycle sustained.

## Configuration
- `SYNC_FIFO_PEAK_EN` defined: `peak` register tracks max(count) seen. It updates on the edge after count rises above it, is cleared by reset and by `flush`, and saturates at DEPTH.
- Not defined: `peak` tied to 0 and no watermark logic is synthesised.

## Structure
- `fifo_pkg`: `clog2`-derived width helper and the `fifo_count_t` typedef pattern. All parametrised blocks in the datapath share these.
- Sub-module `fifo_ram`: DEPTH×WIDTH storage with one synchronous write port and one asynchronous read port, no reset. Pointer, count and handshake logic stay in `sync_fifo_param`.

## Test plan
All scenarios use WIDTH=8, DEPTH=16, AFULL_LVL=14.
- Reset mid-stream: push 5 words, assert `reset`=0 for one cycle asynchronously → `count`=0, `ovalid`=0, `iready`=0 during reset, `iready`=1 after release.
- Fill: push 0x00..0x0F back-to-back → `afull`=1 after 14th push, `iready`=0 after 16th, `count`=16; a 17th `ivalid` with 0xAA is dropped.
- Drain order and wrap: pop 16 → `odata` 0x00..0x0F in order, `ovalid`=0 after last. Push 0x20..0x27 → pointers wrap past 15 with no corruption.
- Full with push+pop: at count=16, `ivalid`=`oready`=1 → pop accepted, push rejected, count=15.
- Empty with push+pop: at count=0, `ivalid`=`oready`=1 with 0x55 → no pop, count=1, `odata`=0x55 next cycle.
- Flush: count=9 with push+pop asserted and `flush`=1 → count=0, `ovalid`=0. With `SYNC_FIFO_PEAK_EN`, `peak` reads 9 before the flush and 0 after.
